// File: rtl/hub75_column_driver.sv
// HUB75 column driver: requests a two-half column payload, shifts it out as three
// binary-coded bit planes, latches each plane and enables the panel for a weighted time.
module hub75_column_driver #(
  parameter int unsigned NUM_ROWS      = 64,
  parameter int unsigned SCAN_RATE     = 32,
  parameter int unsigned RGB_RES       = 9,
  parameter int unsigned BASE_DISPLAY  = 32,
  parameter int unsigned READY_TIMEOUT = 1024
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]     columns,
  input  logic [$clog2(SCAN_RATE)-1:0]              col_num,
  input  logic                                      data_valid,
  output logic                                      hub75_ready,
  output logic                                      r1,
  output logic                                      g1,
  output logic                                      b1,
  output logic                                      r2,
  output logic                                      g2,
  output logic                                      b2,
  output logic [$clog2(SCAN_RATE)-1:0]              addr,
  output logic                                      sclk,
  output logic                                      latch,
  output logic                                      oe_n
);

  localparam int unsigned AddrW = $clog2(SCAN_RATE);
  localparam int unsigned PixW  = $clog2(NUM_ROWS);
  localparam int unsigned WaitW = $clog2(READY_TIMEOUT + 1);
  localparam int unsigned DispW = $clog2((BASE_DISPLAY << 2) + 1);

  localparam logic [PixW-1:0]  PixLast  = PixW'(NUM_ROWS - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(READY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StReq,
    StWaitData,
    StShift,
    StLatch,
    StDisplay
  } state_e;

  typedef logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] payload_t;

  state_e               state_q, state_d;
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [DispW-1:0]     disp_cnt_q, disp_cnt_d;
  logic [PixW-1:0]      pix_cnt_q, pix_cnt_d;
  logic                 phase_q, phase_d;
  logic [1:0]           plane_q, plane_d;
  payload_t             pix_buf_q, pix_buf_d;
  logic [AddrW-1:0]     addr_buf_q, addr_buf_d;

  // Pin registers: every pin is a flop so the connector sees glitch-free edges.
  logic                 ready_q, ready_d;
  logic                 sclk_q, sclk_d;
  logic                 latch_q, latch_d;
  logic                 oe_n_q, oe_n_d;
  logic [5:0]           rgb_q, rgb_d;
  logic [AddrW-1:0]     addr_q, addr_d;

  logic [DispW-1:0]     disp_len;
  logic [DispW-1:0]     disp_last;
  logic [RGB_RES-1:0]   upper_px;
  logic [RGB_RES-1:0]   lower_px;

  // Returns {r, g, b} for the given bit plane of one pixel.
  function automatic logic [2:0] plane_bits(input logic [RGB_RES-1:0] px,
                                            input logic [1:0]         pl);
    logic [2:0] bits;
    unique case (pl)
      2'd0:    bits = {px[6], px[3], px[0]};
      2'd1:    bits = {px[7], px[4], px[1]};
      2'd2:    bits = {px[8], px[5], px[2]};
      default: bits = 3'b000;
    endcase
    return bits;
  endfunction

  assign disp_len  = DispW'(BASE_DISPLAY) << plane_q;
  assign disp_last = disp_len - DispW'(1);
  assign upper_px  = pix_buf_q[0][pix_cnt_q];
  assign lower_px  = pix_buf_q[1][pix_cnt_q];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    disp_cnt_d = disp_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    phase_d    = phase_q;
    plane_d    = plane_q;
    pix_buf_d  = pix_buf_q;
    addr_buf_d = addr_buf_q;
    ready_d    = 1'b0;
    sclk_d     = 1'b0;
    latch_d    = 1'b0;
    oe_n_d     = 1'b1;
    rgb_d      = rgb_q;
    addr_d     = addr_q;

    unique case (state_q)
      StReq: begin
        ready_d    = 1'b1;
        wait_cnt_d = '0;
        state_d    = StWaitData;
      end

      StWaitData: begin
        // A strobe on the expiry cycle still wins over the re-request.
        if (data_valid) begin
          pix_buf_d  = columns;
          addr_buf_d = col_num;
          plane_d    = 2'd0;
          pix_cnt_d  = PixLast;
          phase_d    = 1'b0;
          state_d    = StShift;
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StReq;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end

      StShift: begin
        if (!phase_q) begin
          rgb_d   = {plane_bits(upper_px, plane_q), plane_bits(lower_px, plane_q)};
          phase_d = 1'b1;
        end else begin
          sclk_d  = 1'b1;
          phase_d = 1'b0;
          if (pix_cnt_q == '0) begin
            state_d = StLatch;
          end else begin
            pix_cnt_d = pix_cnt_q - PixW'(1);
          end
        end
      end

      StLatch: begin
        latch_d    = 1'b1;
        addr_d     = addr_buf_q;
        disp_cnt_d = '0;
        state_d    = StDisplay;
      end

      StDisplay: begin
        oe_n_d = 1'b0;
        if (disp_cnt_q == disp_last) begin
          if (plane_q == 2'd2) begin
            state_d = StReq;
          end else begin
            plane_d   = plane_q + 2'd1;
            pix_cnt_d = PixLast;
            phase_d   = 1'b0;
            state_d   = StShift;
          end
        end else begin
          disp_cnt_d = disp_cnt_q + DispW'(1);
        end
      end

      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StReq;
      wait_cnt_q <= '0;
      disp_cnt_q <= '0;
      pix_cnt_q  <= '0;
      phase_q    <= 1'b0;
      plane_q    <= 2'd0;
      pix_buf_q  <= '0;
      addr_buf_q <= '0;
      ready_q    <= 1'b0;
      sclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      oe_n_q     <= 1'b1;
      rgb_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      disp_cnt_q <= disp_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      phase_q    <= phase_d;
      plane_q    <= plane_d;
      pix_buf_q  <= pix_buf_d;
      addr_buf_q <= addr_buf_d;
      ready_q    <= ready_d;
      sclk_q     <= sclk_d;
      latch_q    <= latch_d;
      oe_n_q     <= oe_n_d;
      rgb_q      <= rgb_d;
      addr_q     <= addr_d;
    end
  end

  assign hub75_ready = ready_q;
  assign sclk        = sclk_q;
  assign latch       = latch_q;
  assign oe_n        = oe_n_q;
  assign addr        = addr_q;
  assign {r1, g1, b1, r2, g2, b2} = rgb_q;

endmodule

// File: tb/tb_hub75_column_driver.sv
// Directed bench for hub75_column_driver: reset, request timeout, payload shifting,
// plane weighting, ignored strobes, mid-display reset and the timeout/strobe race.
module tb_hub75_column_driver;

  localparam int NR  = 64;
  localparam int SR  = 32;
  localparam int RES = 9;
  localparam int BD  = 32;
  localparam int RT  = 1024;

  typedef logic [1:0][NR-1:0][RES-1:0] payload_t;

  logic           clk = 1'b0;
  logic           rst;
  payload_t       columns;
  logic [4:0]     col_num;
  logic           data_valid;
  logic           hub75_ready;
  logic           r1, g1, b1, r2, g2, b2;
  logic [4:0]     addr;
  logic           sclk, latch, oe_n;

  int checks   = 0;
  int failures = 0;

  int rises, latches, nruns, run_len, ready_cnt, overlap_cnt, addr_chg;
  logic [5:0] bits [0:191];
  int         runs [0:7];
  logic [4:0] latch_addr [0:3];
  logic       sclk_p, latch_p;
  logic [4:0] addr_p;

  always #5 clk = ~clk;

  hub75_column_driver #(
    .NUM_ROWS     (NR),
    .SCAN_RATE    (SR),
    .RGB_RES      (RES),
    .BASE_DISPLAY (BD),
    .READY_TIMEOUT(RT)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .columns    (columns),
    .col_num    (col_num),
    .data_valid (data_valid),
    .hub75_ready(hub75_ready),
    .r1         (r1),
    .g1         (g1),
    .b1         (b1),
    .r2         (r2),
    .g2         (g2),
    .b2         (b2),
    .addr       (addr),
    .sclk       (sclk),
    .latch      (latch),
    .oe_n       (oe_n)
  );

  task automatic mon_clear();
    rises = 0; latches = 0; nruns = 0; run_len = 0; ready_cnt = 0;
    overlap_cnt = 0; addr_chg = 0;
    for (int i = 0; i < 192; i++) bits[i] = 'x;
    for (int i = 0; i < 8; i++) runs[i] = 0;
    for (int i = 0; i < 4; i++) latch_addr[i] = 'x;
    sclk_p = sclk; latch_p = latch; addr_p = addr;
  endtask

  // Advance one cycle and record the pin activity seen at the falling edge.
  task automatic tick();
    @(negedge clk);
    if (sclk === 1'b1 && sclk_p !== 1'b1) begin
      if (rises < 192) bits[rises] = {r1, g1, b1, r2, g2, b2};
      rises++;
    end
    if (latch === 1'b1 && latch_p !== 1'b1) begin
      if (latches < 4) latch_addr[latches] = addr;
      latches++;
    end
    if (oe_n === 1'b0) begin
      run_len++;
      if (addr !== addr_p) addr_chg++;
    end else if (run_len > 0) begin
      if (nruns < 8) runs[nruns] = run_len;
      nruns++;
      run_len = 0;
    end
    if ((latch === 1'b1 && sclk === 1'b1) || (oe_n === 1'b0 && (sclk === 1'b1 || latch === 1'b1)))
      overlap_cnt++;
    if (hub75_ready === 1'b1) ready_cnt++;
    sclk_p = sclk; latch_p = latch; addr_p = addr;
  endtask

  // Called right after a ready pulse was seen; n = edges from capture edge to next ready.
  task automatic run_payload(input payload_t cols, input logic [4:0] col, input int pre,
                             input int inj_at, input payload_t inj_cols,
                             input logic [4:0] inj_col, output int n, output int early);
    early = 0;
    for (int i = 0; i < pre; i++) begin
      tick();
      if (hub75_ready === 1'b1) early++;
    end
    columns = cols; col_num = col; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    mon_clear();
    n = 0;
    for (int i = 1; i <= 700; i++) begin
      if (i == inj_at) begin
        columns = inj_cols; col_num = inj_col; data_valid = 1'b1;
      end
      tick();
      data_valid = 1'b0;
      if (hub75_ready === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid = 1'b0; columns = '0; col_num = '0;
    repeat (3) tick();
    checks++; if (hub75_ready !== 1'b0) begin failures++;
      $display("FAIL reset_ready: got %b expected 0", hub75_ready); end
    checks++; if (oe_n !== 1'b1) begin failures++;
      $display("FAIL reset_oe_n: got %b expected 1", oe_n); end
    checks++; if ({sclk, latch} !== 2'b00) begin failures++;
      $display("FAIL reset_sclk_latch: got %b expected 00", {sclk, latch}); end
    checks++; if (addr !== 5'd0) begin failures++;
      $display("FAIL reset_addr: got %0d expected 0", addr); end
    checks++; if ({r1, g1, b1, r2, g2, b2} !== 6'b0) begin failures++;
      $display("FAIL reset_rgb: got %b expected 000000", {r1, g1, b1, r2, g2, b2}); end
    rst = 1'b0;
    mon_clear();
    tick();
    checks++; if (hub75_ready !== 1'b1) begin failures++;
      $display("FAIL ready_post_reset: got %b expected 1", hub75_ready); end
  endtask

  task automatic test_timeout_repulse();
    int n;
    n = 0;
    mon_clear();
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (i == 1) begin
        checks++; if (hub75_ready !== 1'b0) begin failures++;
          $display("FAIL ready_width: got %b expected 0", hub75_ready); end
      end
      if (hub75_ready === 1'b1) begin n = i; break; end
    end
    checks++; if (n != 1025) begin failures++;
      $display("FAIL timeout_period: got %0d expected 1025", n); end
    checks++; if (rises != 0 || latches != 0 || nruns != 0 || run_len != 0) begin failures++;
      $display("FAIL idle_pins: got rises=%0d latches=%0d oe_runs=%0d expected all 0",
               rises, latches, nruns + run_len); end
  endtask

  task automatic test_full_white();
    payload_t cols;
    int n, early, bad;
    for (int h = 0; h < 2; h++) for (int p = 0; p < NR; p++) cols[h][p] = 9'h1FF;
    run_payload(cols, 5'd5, 1, -1, '0, 5'd0, n, early);
    checks++; if (early != 0) begin failures++;
      $display("FAIL white_early_ready: got %0d expected 0", early); end
    checks++; if (n != 612) begin failures++;
      $display("FAIL white_latency: got %0d expected 612", n); end
    checks++; if (rises != 192) begin failures++;
      $display("FAIL white_sclk_rises: got %0d expected 192", rises); end
    checks++; if (latches != 3) begin failures++;
      $display("FAIL white_latches: got %0d expected 3", latches); end
    bad = 0;
    for (int i = 0; i < 192; i++) if (bits[i] !== 6'h3F) bad++;
    checks++; if (bad != 0) begin failures++;
      $display("FAIL white_bits: got %0d wrong bits expected 0", bad); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (latch_addr[i] !== 5'd5) begin failures++;
        $display("FAIL white_addr latch %0d: got %0d expected 5", i, latch_addr[i]); end
    end
    checks++; if (nruns != 3 || runs[0] != 32 || runs[1] != 64 || runs[2] != 128) begin
      failures++;
      $display("FAIL white_oe_runs: got n=%0d %0d/%0d/%0d expected n=3 32/64/128",
               nruns, runs[0], runs[1], runs[2]); end
    checks++; if (addr_chg != 0 || overlap_cnt != 0) begin failures++;
      $display("FAIL white_pin_rules: got addr_chg=%0d overlap=%0d expected 0/0",
               addr_chg, overlap_cnt); end
  endtask

  task automatic test_single_pixel(input logic [4:0] col);
    payload_t cols;
    int n, early, bad;
    logic [5:0] exp;
    cols = '0;
    cols[0][63] = 9'b100_010_001;
    run_payload(cols, col, 1, -1, '0, 5'd0, n, early);
    checks++; if (n != 612 || early != 0) begin failures++;
      $display("FAIL pixel_latency: got n=%0d early=%0d expected 612/0", n, early); end
    bad = 0;
    for (int i = 0; i < 192; i++) begin
      exp = 6'b0;
      if (i == 0)   exp = 6'b001_000;
      if (i == 64)  exp = 6'b010_000;
      if (i == 128) exp = 6'b100_000;
      if (bits[i] !== exp) begin
        if (bad == 0) $display("FAIL pixel_bits idx %0d: got %b expected %b", i, bits[i], exp);
        bad++;
      end
    end
    checks++; if (bad != 0) begin failures++;
      $display("FAIL pixel_bits_total: got %0d wrong expected 0", bad); end
    checks++; if (latch_addr[0] !== col || latch_addr[2] !== col) begin failures++;
      $display("FAIL pixel_addr: got %0d/%0d expected %0d", latch_addr[0], latch_addr[2], col); end
  endtask

  task automatic test_ignore_midshift();
    payload_t cols, junk;
    int n, early, bad;
    logic [5:0] exp;
    cols = '0;
    cols[1][0] = 9'b001_100_010;
    for (int h = 0; h < 2; h++) for (int p = 0; p < NR; p++) junk[h][p] = 9'h1FF;
    run_payload(cols, 5'd9, 1, 20, junk, 5'd3, n, early);
    checks++; if (n != 612) begin failures++;
      $display("FAIL ignore_latency: got %0d expected 612", n); end
    bad = 0;
    for (int i = 0; i < 192; i++) begin
      exp = 6'b0;
      if (i == 63)  exp = 6'b000_100;
      if (i == 127) exp = 6'b000_001;
      if (i == 191) exp = 6'b000_010;
      if (bits[i] !== exp) bad++;
    end
    checks++; if (bad != 0) begin failures++;
      $display("FAIL ignore_bits: got %0d wrong expected 0", bad); end
    checks++; if (addr !== 5'd9 || latch_addr[0] !== 5'd9) begin failures++;
      $display("FAIL ignore_addr: got %0d expected 9", addr); end
  endtask

  task automatic test_timeout_accept();
    payload_t cols;
    int n, early, bad;
    for (int h = 0; h < 2; h++) for (int p = 0; p < NR; p++) cols[h][p] = 9'h1FF;
    run_payload(cols, 5'd2, RT - 1, -1, '0, 5'd0, n, early);
    checks++; if (early != 0) begin failures++;
      $display("FAIL race_early_ready: got %0d expected 0", early); end
    checks++; if (n != 612) begin failures++;
      $display("FAIL race_latency: got %0d expected 612", n); end
    bad = 0;
    for (int i = 0; i < 192; i++) if (bits[i] !== 6'h3F) bad++;
    checks++; if (rises != 192 || bad != 0 || latch_addr[0] !== 5'd2) begin failures++;
      $display("FAIL race_payload: got rises=%0d bad=%0d addr=%0d expected 192/0/2",
               rises, bad, latch_addr[0]); end
  endtask

  task automatic test_reset_in_display();
    payload_t cols;
    int found;
    for (int h = 0; h < 2; h++) for (int p = 0; p < NR; p++) cols[h][p] = 9'h1FF;
    tick();
    columns = cols; col_num = 5'd5; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    mon_clear();
    found = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (latches == 2 && run_len == 10) begin found = 1; break; end
    end
    checks++; if (found != 1 || oe_n !== 1'b0) begin failures++;
      $display("FAIL plane1_display_reached: got found=%0d oe_n=%b expected 1/0", found, oe_n); end
    rst = 1'b1;
    tick();
    checks++; if (oe_n !== 1'b1 || addr !== 5'd0 || latch !== 1'b0) begin failures++;
      $display("FAIL midreset_pins: got oe_n=%b addr=%0d latch=%b expected 1/0/0",
               oe_n, addr, latch); end
    checks++; if (sclk !== 1'b0 || hub75_ready !== 1'b0) begin failures++;
      $display("FAIL midreset_sclk_ready: got %b/%b expected 0/0", sclk, hub75_ready); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (hub75_ready !== 1'b1) begin failures++;
      $display("FAIL ready_after_midreset: got %b expected 1", hub75_ready); end
    test_single_pixel(5'd7);
  endtask

  initial begin
    test_reset();
    test_timeout_repulse();
    test_full_white();
    test_single_pixel(5'd12);
    test_ignore_midshift();
    test_timeout_accept();
    test_reset_in_display();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
